// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - single-port memory arbiter between instruction fetch and data requesters
//
// Purpose:
//    Shares one single-port memory between the fetch (IF) and data (MEM-stage)
//    requesters. It allows one outstanding transaction at a time and sequences
//    it with a fixed-latency IDLE/BUSY FSM. Data requests normally win, but a
//    starvation counter bounds how long fetch can be held off.
//
// Optional feature (macro MEM_PORT_ARB_PERF_EN):
//    Adds the perf_if_stall / perf_d_stall saturating stall-cycle counters.
//
// Ports:
//    clk, rst                       clock (rising edge), synchronous active-high reset
//    if_req/if_addr                 fetch request; held until if_gnt
//    if_gnt/if_rvalid/if_rdata      fetch grant, 1-cycle data-valid pulse, fetched word
//    d_req/d_we/d_addr/d_wdata      data request (load/store); held until d_gnt
//    d_gnt/d_rvalid/d_rdata         data grant, 1-cycle load-data / store-done pulse, load word
//    mem_req/mem_we/mem_addr/mem_wdata  1-cycle strobe and qualified fields to the memory
//    mem_rdata                      memory read data, valid MEM_LATENCY cycles after mem_req
//    perf_if_stall/perf_d_stall     (MEM_PORT_ARB_PERF_EN only) request-denied cycle counts

module mem_port_arbiter #(
   parameter int ADDR_W       = 32,
   parameter int DATA_W       = 32,
   parameter int MEM_LATENCY  = 2,
   parameter int STARVE_LIMIT = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic              if_gnt,
   output logic              if_rvalid,
   output logic [DATA_W-1:0] if_rdata,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic              d_gnt,
   output logic              d_rvalid,
   output logic [DATA_W-1:0] d_rdata,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
`ifdef MEM_PORT_ARB_PERF_EN
   ,
   output logic [31:0]       perf_if_stall,
   output logic [31:0]       perf_d_stall
`endif
);

   localparam logic [3:0] LAT        = 4'(MEM_LATENCY);
   localparam logic [7:0] STARVE_MAX = 8'(STARVE_LIMIT);

   typedef enum logic {
      S_IDLE = 1'b0,
      S_BUSY = 1'b1
   } state_t;

   state_t     r_state;
   state_t     w_state_nxt;
   logic [3:0] r_lat_cnt;
   logic [3:0] w_lat_cnt_nxt;
   logic       r_owner_d;        // 1 = data requester owns the outstanding access
   logic       w_owner_d_nxt;
   logic [7:0] r_starve_cnt;
   logic       w_fetch_first;

   // Fetch overrides data priority once it has been denied STARVE_LIMIT cycles.
   assign w_fetch_first = (r_starve_cnt == STARVE_MAX);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= S_IDLE;
         r_lat_cnt    <= '0;
         r_owner_d    <= 1'b0;
         r_starve_cnt <= '0;
      end else begin
         r_state   <= w_state_nxt;
         r_lat_cnt <= w_lat_cnt_nxt;
         r_owner_d <= w_owner_d_nxt;
         if (if_gnt)
            r_starve_cnt <= '0;
         else if (if_req && (r_starve_cnt != STARVE_MAX))
            r_starve_cnt <= r_starve_cnt + 8'd1;
      end
   end

   // Grants and memory strobes are combinational in the grant cycle; everything
   // is forced low while rst is high so a held request cannot leak through.
   always_comb begin
      w_state_nxt   = r_state;
      w_lat_cnt_nxt = r_lat_cnt;
      w_owner_d_nxt = r_owner_d;
      if_gnt        = 1'b0;
      d_gnt         = 1'b0;
      if_rvalid     = 1'b0;
      d_rvalid      = 1'b0;
      if_rdata      = '0;
      d_rdata       = '0;
      mem_req       = 1'b0;
      mem_we        = 1'b0;
      mem_addr      = '0;
      mem_wdata     = '0;
      if (!rst) begin
         case (r_state)
            S_IDLE: begin
               if (if_req && (!d_req || w_fetch_first)) begin
                  if_gnt        = 1'b1;
                  mem_req       = 1'b1;
                  mem_addr      = if_addr;
                  w_state_nxt   = S_BUSY;
                  w_lat_cnt_nxt = 4'd1;
                  w_owner_d_nxt = 1'b0;
               end else if (d_req) begin
                  d_gnt         = 1'b1;
                  mem_req       = 1'b1;
                  mem_we        = d_we;
                  mem_addr      = d_addr;
                  mem_wdata     = d_wdata;
                  w_state_nxt   = S_BUSY;
                  w_lat_cnt_nxt = 4'd1;
                  w_owner_d_nxt = 1'b1;
               end
            end
            S_BUSY: begin
               // r_lat_cnt holds the number of cycles elapsed since the grant.
               if (r_lat_cnt == LAT) begin
                  if (r_owner_d) begin
                     d_rvalid = 1'b1;
                     d_rdata  = mem_rdata;
                  end else begin
                     if_rvalid = 1'b1;
                     if_rdata  = mem_rdata;
                  end
                  w_state_nxt   = S_IDLE;
                  w_lat_cnt_nxt = '0;
               end else begin
                  w_lat_cnt_nxt = r_lat_cnt + 4'd1;
               end
            end
            default: w_state_nxt = S_IDLE;
         endcase
      end
   end

`ifdef MEM_PORT_ARB_PERF_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         perf_if_stall <= '0;
         perf_d_stall  <= '0;
      end else begin
         if (if_req && !if_gnt && (perf_if_stall != 32'hFFFF_FFFF))
            perf_if_stall <= perf_if_stall + 32'd1;
         if (d_req && !d_gnt && (perf_d_stall != 32'hFFFF_FFFF))
            perf_d_stall <= perf_d_stall + 32'd1;
      end
   end
`endif

endmodule
